seq_signed_divider: RTL

//  Sequential signed radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.

---
 rtl/seq_signed_divider_if.sv | 25 ++
 rtl/seq_signed_divider.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider_if.sv
// Handshake and operand/result bundle for seq_signed_divider.
// master drives start and operands; slave returns status and results.
interface seq_signed_divider_if #(
    parameter int W = 8
);
    logic             start;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider, 2W/W -> W quotient + W remainder.
// Define DIVIDER_ZERO_FAST_EN to let divide-by-zero skip the iterations.
module seq_signed_divider #(
    parameter int W = 8
) (
    input logic                clk,
    input logic                rst,
    seq_signed_divider_if.slave bus
);

    localparam int CW = $clog2(W + 1);

`ifdef DIVIDER_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t         state;
    logic [2*W-1:0] acc;
    logic [W-1:0]   dvs_mag;
    logic [CW-1:0]  cnt;
    logic           sign_q;
    logic           sign_r;
    logic           dz_flag;
    logic           ovf_flag;

    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   quot_q;
    logic [W-1:0]   rem_q;
    logic           ovf_q;
    logic           dz_q;

    // Load-time magnitudes; 2W+1 bits so the most negative dividend cannot wrap.
    logic [2*W:0]   dnd_ext;
    logic [2*W:0]   dnd_abs;
    logic [W-1:0]   dvs_abs;
    logic           load_dz;
    logic           load_ovf;

    always_comb begin
        dnd_ext  = {bus.dividend[2*W-1], bus.dividend};
        dnd_abs  = bus.dividend[2*W-1] ? -dnd_ext : dnd_ext;
        dvs_abs  = bus.divisor[W-1] ? -bus.divisor : bus.divisor;
        load_dz  = (bus.divisor == '0);
        load_ovf = (dnd_abs[2*W:W] >= {1'b0, dvs_abs});
    end

    // One restoring step: shift, trial-subtract, keep or restore.
    logic [2*W:0]   shifted;
    logic [W:0]     diff;
    logic [2*W-1:0] next_acc;

    always_comb begin
        shifted  = {acc, 1'b0};
        diff     = shifted[2*W:W] - {1'b0, dvs_mag};
        next_acc = shifted[2*W-1:0];
        if (!diff[W]) begin
            next_acc = {diff[W-1:0], shifted[W-1:1], 1'b1};
        end
    end

    // Sign application and saturation for the final result.
    logic [W-1:0]   q_mag;
    logic [W-1:0]   r_mag;
    logic           q_ovf;
    logic [W-1:0]   res_q;
    logic [W-1:0]   res_r;
    logic           res_ovf;
    logic           res_dz;

    always_comb begin
        q_mag   = acc[W-1:0];
        r_mag   = acc[2*W-1:W];
        q_ovf   = ovf_flag
                  || (!sign_q && q_mag[W-1])
                  || (sign_q && (q_mag > MIN_NEG));
        res_q   = sign_q ? -q_mag : q_mag;
        res_r   = sign_r ? -r_mag : r_mag;
        res_ovf = 1'b0;
        res_dz  = 1'b0;
        if (dz_flag) begin
            res_dz = 1'b1;
            res_q  = sign_r ? MIN_NEG : MAX_POS;
            res_r  = '0;
        end else if (q_ovf) begin
            res_ovf = 1'b1;
            res_q   = sign_q ? MIN_NEG : MAX_POS;
            res_r   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            dvs_mag  <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dz_flag  <= 1'b0;
            ovf_flag <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        acc      <= dnd_abs[2*W-1:0];
                        dvs_mag  <= dvs_abs;
                        cnt      <= '0;
                        sign_q   <= bus.dividend[2*W-1] ^ bus.divisor[W-1];
                        sign_r   <= bus.dividend[2*W-1];
                        dz_flag  <= load_dz;
                        ovf_flag <= load_ovf;
                        busy_q   <= 1'b1;
                        state    <= (FAST_ZERO && load_dz) ? FIX : ITER;
                    end else begin
                        state <= IDLE;
                    end
                end
                ITER: begin
                    acc <= next_acc;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quot_q <= res_q;
                    rem_q  <= res_r;
                    ovf_q  <= res_ovf;
                    dz_q   <= res_dz;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= DONE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dz_q;

endmodule
